// File: rtl/vga_pkg.sv
// Shared definitions for the VGA framebuffer fetch path.
// Holds the controller state encoding, the default frame geometry and the word stride.
// Framebuffer words are 32-bit, so consecutive pixels sit 4 bytes apart.
package vga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_FILL  = 2'd2,
        ST_RUN   = 2'd3
    } vga_state_t;

    localparam int unsigned VGA_H_ACTIVE     = 640;
    localparam int unsigned VGA_V_ACTIVE     = 480;
    localparam int unsigned VGA_FRAME_PIXELS = VGA_H_ACTIVE * VGA_V_ACTIVE;
    localparam int unsigned VGA_FB_BASE      = 0;
    localparam int unsigned VGA_WORD_STRIDE  = 4;

endpackage

// File: rtl/vga_credit_counter.sv
// Counts memory reads that have been accepted but whose data has not yet returned.
// Latency: count reflects inc/dec on the cycle after they occur.
// Backpressure: never counts above MAX_OUT or below zero; simultaneous inc and dec cancel.
module vga_credit_counter #(
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Up/down count with saturation at both ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            case ({i_inc, i_dec})
                2'b10: if (32'(r_count) < MAX_OUT) r_count <= r_count + CNT_W'(1);
                2'b01: if (r_count != '0)          r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/vga_fetch_ctrl.sv
// Fetches framebuffer words from memory into the 8-deep pixel FIFO for VGA scan-out.
// Latency: a read issues combinationally in FILL/RUN; returned data is written to the FIFO in the same cycle.
// Backpressure: reads are credit-limited by FIFO free slots and MAX_OUT; a stalled request is held until accepted.
module vga_fetch_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned FB_BASE      = VGA_FB_BASE,
    parameter int unsigned FRAME_PIXELS = VGA_FRAME_PIXELS,
    parameter int unsigned MAX_OUT      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              frame_start,
    input  logic              pixel_req,
    input  logic [4:0]        fifo_freeslots,
    input  logic              fifo_empty,
    output logic              fifo_wr_en,
    output logic              fifo_rd_en,
    output logic              fifo_flush,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    input  logic              mem_waitrequest,
    input  logic              mem_readdatavalid,
    output logic              underflow,
    output logic [1:0]        state
);

    localparam int unsigned       CNT_W     = $clog2(MAX_OUT + 1);
    localparam int unsigned       WORD_W    = $clog2(FRAME_PIXELS + 1);
    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(FB_BASE);
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(VGA_WORD_STRIDE);

    vga_state_t        r_state;
    vga_state_t        w_state_nxt;
    logic              r_pend;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_words;
    logic              r_underflow;
    logic [CNT_W-1:0]  w_outstanding;
    logic              w_fetching;
    logic              w_issue;
    logic              w_mem_read;
    logic              w_accept;
    logic              w_bus_quiet;
    logic              w_frame_done;

    vga_credit_counter #(
        .MAX_OUT (MAX_OUT),
        .CNT_W   (CNT_W)
    ) u_credit (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_accept),
        .i_dec   (mem_readdatavalid),
        .o_count (w_outstanding)
    );

    // A new read needs a free FIFO slot for every word already in flight plus itself.
    assign w_fetching   = (r_state == ST_FILL) || (r_state == ST_RUN);
    assign w_issue      = w_fetching && !r_pend
                       && (32'(r_words) < FRAME_PIXELS)
                       && (32'(w_outstanding) < MAX_OUT)
                       && (32'(fifo_freeslots) > 32'(w_outstanding));
    // A request that met waitrequest stays asserted regardless of state changes.
    assign w_mem_read   = r_pend || w_issue;
    assign w_accept     = w_mem_read && !mem_waitrequest;
    assign w_bus_quiet  = (w_outstanding == '0) && !w_mem_read;
    assign w_frame_done = (32'(r_words) == FRAME_PIXELS) && (w_outstanding == '0);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and FIFO strobes.
    always_comb begin
        w_state_nxt = r_state;
        fifo_flush  = (r_state == ST_FLUSH);
        fifo_wr_en  = mem_readdatavalid && w_fetching;
        fifo_rd_en  = (r_state == ST_RUN) && pixel_req && !fifo_empty;
        if (frame_start) begin
            w_state_nxt = ST_FLUSH;
        end else begin
            case (r_state)
                ST_FLUSH: if (w_bus_quiet) w_state_nxt = enable ? ST_FILL : ST_IDLE;
                ST_FILL:  if ((fifo_freeslots == '0) || w_frame_done) w_state_nxt = ST_RUN;
                default:  ;
            endcase
        end
    end

    // Request tracking: hold a stalled request, step the address on acceptance, rewind during flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend  <= 1'b0;
            r_addr  <= BASE_ADDR;
            r_words <= '0;
        end else begin
            r_pend <= w_mem_read && mem_waitrequest;
            if (w_accept) begin
                r_addr  <= r_addr + STRIDE;
                r_words <= r_words + WORD_W'(1);
            end else if ((r_state == ST_FLUSH) && !w_mem_read) begin
                r_addr  <= BASE_ADDR;
                r_words <= '0;
            end
        end
    end

    // Sticky underflow: scan-out asked for a pixel the FIFO did not have.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_underflow <= 1'b0;
        end else if ((r_state == ST_RUN) && pixel_req && fifo_empty) begin
            r_underflow <= 1'b1;
        end
    end

    assign mem_read    = w_mem_read;
    assign mem_address = r_addr;
    assign underflow   = r_underflow;
    assign state       = r_state;

endmodule

// File: tb/tb_vga_fetch_ctrl.sv
// Directed bench for vga_fetch_ctrl with a behavioural 8-deep FIFO and a fixed-latency memory.
// Latency: one stimulus cycle per clock; outputs sampled 1 ns after the falling edge.
// Backpressure: memory stalls are driven directly through mem_waitrequest.
module tb_vga_fetch_ctrl;
    import vga_pkg::*;

    localparam int FP    = 16;
    localparam int MO    = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        frame_start;
    logic        pixel_req;
    logic [4:0]  fifo_freeslots;
    logic        fifo_empty;
    logic        fifo_wr_en;
    logic        fifo_rd_en;
    logic        fifo_flush;
    logic        mem_read;
    logic [31:0] mem_address;
    logic        mem_waitrequest;
    logic        mem_readdatavalid;
    logic        underflow;
    logic [1:0]  state;

    always #5 clk = ~clk;

    vga_fetch_ctrl #(
        .ADDR_W       (32),
        .FB_BASE      (0),
        .FRAME_PIXELS (FP),
        .MAX_OUT      (MO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .frame_start       (frame_start),
        .pixel_req         (pixel_req),
        .fifo_freeslots    (fifo_freeslots),
        .fifo_empty        (fifo_empty),
        .fifo_wr_en        (fifo_wr_en),
        .fifo_rd_en        (fifo_rd_en),
        .fifo_flush        (fifo_flush),
        .mem_read          (mem_read),
        .mem_address       (mem_address),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdatavalid (mem_readdatavalid),
        .underflow         (underflow),
        .state             (state)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 1;
    int          fcnt = 0;
    int          out_cnt = 0;
    int          due_q[$];
    logic [31:0] exp_addr = 32'h0;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] prev_addr = 32'h0;
    int          acc_frame = 0;
    int          n_wr = 0;
    int          n_rd = 0;
    int          n_acc = 0;
    int          max_out = 0;
    int          stall_cyc = 0;
    int          rdv_in_flush = 0;
    int          flush_cyc = 0;
    int          mem_read_cyc = 0;
    logic        prev_stall = 1'b0;
    logic        prev_fl = 1'b0;
    logic        s_acc, s_wr, s_rd, s_fl, s_uf;
    logic [1:0]  s_state;
    logic        uf_seen = 1'b0;
    logic        uf_pending = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive model-derived inputs, sample, check invariants, advance the models.
    task automatic cycle();
        logic rdv_now;
        logic fs_now;
        fifo_freeslots    = 5'(DEPTH - fcnt);
        fifo_empty        = (fcnt == 0);
        mem_readdatavalid = (due_q.size() > 0) && (due_q[0] <= cyc);
        #1;
        rdv_now = mem_readdatavalid;
        fs_now  = frame_start;
        s_acc   = mem_read && !mem_waitrequest;
        s_wr    = fifo_wr_en;
        s_rd    = fifo_rd_en;
        s_fl    = fifo_flush;
        s_uf    = underflow;
        s_state = state;
        if (prev_stall) begin
            chk("stall_hold_read", 32'(mem_read), 32'd1);
            chk("stall_hold_addr", mem_address, prev_addr);
        end
        if (s_acc) begin
            chk("accept_addr", mem_address, exp_addr);
            exp_addr  = exp_addr + 32'd4;
            last_addr = mem_address;
            acc_frame++;
            n_acc++;
        end
        if (s_fl) begin
            chk("no_write_in_flush", 32'(s_wr), 32'd0);
            flush_cyc++;
            if (rdv_now) rdv_in_flush++;
        end
        if (s_wr) chk("write_needs_data", 32'(rdv_now), 32'd1);
        if (prev_fl && !s_fl) chk("flush_until_drained", 32'(out_cnt), 32'd0);
        chk("credit_bound", 32'((fcnt + out_cnt <= DEPTH) && (out_cnt <= MO)), 32'd1);
        if (out_cnt > max_out) max_out = out_cnt;
        if (mem_read && mem_waitrequest) stall_cyc++;
        if (mem_read) mem_read_cyc++;
        prev_stall = mem_read && mem_waitrequest;
        prev_addr  = mem_address;
        prev_fl    = s_fl;
        @(posedge clk);
        if (s_fl) fcnt = 0;
        else      fcnt = fcnt + int'(s_wr) - int'(s_rd);
        if (s_acc) due_q.push_back(cyc + lat);
        if (rdv_now) void'(due_q.pop_front());
        out_cnt = out_cnt + int'(s_acc) - int'(rdv_now);
        if (s_wr) n_wr++;
        if (s_rd) n_rd++;
        if (fs_now) begin
            exp_addr  = 32'h0;
            acc_frame = 0;
        end
        cyc++;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with every input trying to provoke an output.
        rst               = 1'b0;
        enable            = 1'b1;
        frame_start       = 1'b1;
        pixel_req         = 1'b1;
        fifo_freeslots    = 5'd8;
        fifo_empty        = 1'b0;
        mem_waitrequest   = 1'b0;
        mem_readdatavalid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_state",      32'(state),       32'd0);
        chk("rst_mem_read",   32'(mem_read),    32'd0);
        chk("rst_mem_addr",   mem_address,      32'h0);
        chk("rst_flush",      32'(fifo_flush),  32'd0);
        chk("rst_wr_en",      32'(fifo_wr_en),  32'd0);
        chk("rst_rd_en",      32'(fifo_rd_en),  32'd0);
        chk("rst_underflow",  32'(underflow),   32'd0);
        frame_start       = 1'b0;
        pixel_req         = 1'b0;
        mem_readdatavalid = 1'b0;
        rst               = 1'b1;

        // No fetch before the first frame_start.
        repeat (4) cycle();
        chk("idle_no_read", 32'(mem_read_cyc), 32'd0);
        chk("idle_state",   32'(s_state),      32'(ST_IDLE));

        // Zero-wait fill: 8 reads from 0x0, RUN once the FIFO is full.
        frame_start = 1'b1;
        repeat (25) cycle();
        chk("fill_state_run", 32'(s_state),   32'(ST_RUN));
        chk("fill_accepts",   32'(acc_frame), 32'd8);
        chk("fill_writes",    32'(n_wr),      32'd8);
        chk("fill_fifo_lvl",  32'(fcnt),      32'd8);
        chk("fill_flush_len", 32'(flush_cyc), 32'd1);
        chk("fill_last_addr", last_addr,      32'h1C);

        // Scan out 16 pixels; same-cycle return/accept must not leak credits.
        pixel_req = 1'b1;
        repeat (16) cycle();
        pixel_req = 1'b0;
        repeat (6) cycle();
        chk("run_reads",      32'(n_rd),      32'd16);
        chk("run_accepts",    32'(acc_frame), 32'd16);
        chk("run_last_addr",  last_addr,      32'h3C);
        chk("run_writes",     32'(n_wr),      32'd16);
        chk("run_fifo_lvl",   32'(fcnt),      32'd0);
        chk("run_no_uflow",   32'(s_uf),      32'd0);

        // 5-cycle stall on the first request of a new frame, 3-cycle read latency.
        lat             = 3;
        mem_waitrequest = 1'b1;
        frame_start     = 1'b1;
        stall_cyc       = 0;
        max_out         = 0;
        repeat (7) cycle();
        mem_waitrequest = 1'b0;
        repeat (30) cycle();
        chk("stall_cycles",   32'(stall_cyc), 32'd5);
        chk("stall_max_out",  32'(max_out),   32'd3);
        chk("stall_state",    32'(s_state),   32'(ST_RUN));
        chk("stall_accepts",  32'(acc_frame), 32'd8);
        chk("stall_fifo_lvl", 32'(fcnt),      32'd8);

        // frame_start with 3 reads in flight: they drain during FLUSH unwritten.
        pixel_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (out_cnt == 3) break;
        end
        chk("pre_flush_outstanding", 32'(out_cnt), 32'd3);
        frame_start  = 1'b1;
        pixel_req    = 1'b0;
        rdv_in_flush = 0;
        flush_cyc    = 0;
        repeat (30) cycle();
        chk("flush_discards", 32'(rdv_in_flush), 32'd3);
        chk("flush_len",      32'(flush_cyc),    32'd4);
        chk("refill_state",   32'(s_state),      32'(ST_RUN));
        chk("refill_accepts", 32'(acc_frame),    32'd8);
        chk("refill_fifo",    32'(fcnt),         32'd8);

        // Memory stalled while scan-out drains the FIFO: underflow one cycle after empty.
        mem_waitrequest = 1'b1;
        pixel_req       = 1'b1;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (uf_pending) begin
                chk("underflow_next_cycle", 32'(s_uf), 32'd1);
                uf_pending = 1'b0;
            end
            if (fifo_empty) begin
                chk("rd_en_when_empty", 32'(s_rd), 32'd0);
                if (!uf_seen) begin
                    chk("underflow_not_early", 32'(s_uf), 32'd0);
                    uf_seen    = 1'b1;
                    uf_pending = 1'b1;
                end
            end
        end
        chk("underflow_observed", 32'(uf_seen), 32'd1);
        mem_waitrequest = 1'b0;
        pixel_req       = 1'b0;
        repeat (20) cycle();
        chk("underflow_sticky", 32'(s_uf), 32'd1);

        // enable low at frame_start: FLUSH then IDLE, no reads.
        enable       = 1'b0;
        frame_start  = 1'b1;
        mem_read_cyc = 0;
        flush_cyc    = 0;
        repeat (16) cycle();
        chk("disable_no_read",  32'(mem_read_cyc), 32'd0);
        chk("disable_flush",    32'(flush_cyc),    32'd1);
        chk("disable_state",    32'(s_state),      32'(ST_IDLE));

        // Only reset clears underflow.
        rst = 1'b0;
        #2;
        chk("rst2_underflow", 32'(underflow),   32'd0);
        chk("rst2_state",     32'(state),       32'd0);
        chk("rst2_addr",      mem_address,      32'h0);
        rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
